// File: rtl/mgc_chan_fifo_wait_grn.sv
// Channel FIFO between an ld/vd producer and an lz/vz consumer.
// Supports any depth >= 1 and reports occupancy (size) and almost-full (afull).
module mgc_chan_fifo_wait_grn #(
  parameter int rscid     = 0,
  parameter int width     = 8,
  parameter int fifo_sz   = 4,
  parameter int ph_log2   = 2,
  parameter int afull_lvl = 3
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               ld,
  input  logic [width-1:0]   d,
  output logic               vd,
  output logic               lz,
  output logic [width-1:0]   z,
  input  logic               vz,
  output logic [ph_log2:0]   size,
  output logic               afull
);

  // Pointers keep at least one bit so a single-entry FIFO still elaborates.
  localparam int              PW    = (ph_log2 < 1) ? 1 : ph_log2;
  localparam int              CW    = ph_log2 + 1;
  localparam logic [CW-1:0]   DEPTH = CW'(fifo_sz);
  localparam logic [CW-1:0]   AFULL = CW'(afull_lvl);
  localparam logic [PW-1:0]   LAST  = PW'(fifo_sz - 1);

  if (fifo_sz < 1 || afull_lvl < 1 || afull_lvl > fifo_sz ||
      (1 << ph_log2) < fifo_sz || rscid < 0) begin : g_badParams
    $error("mgc_chan_fifo_wait_grn: illegal parameter combination");
  end

  logic [width-1:0] r_mem [fifo_sz];
  logic [PW-1:0]    r_rdPtr;
  logic [PW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_count;

  logic             w_wrEn;
  logic             w_rdEn;
  logic [PW-1:0]    w_rdPtrNxt;
  logic [PW-1:0]    w_wrPtrNxt;
  logic [CW-1:0]    w_countNxt;

  assign vd    = ~arst & (r_count < DEPTH);
  assign lz    = (r_count != '0);
  assign z     = r_mem[r_rdPtr];
  assign size  = r_count;
  assign afull = (r_count >= AFULL);

  assign w_wrEn = ld & vd;
  assign w_rdEn = lz & vz;

  always_comb begin
    w_rdPtrNxt = r_rdPtr;
    w_wrPtrNxt = r_wrPtr;
    w_countNxt = r_count;
    if (w_rdEn) w_rdPtrNxt = (r_rdPtr == LAST) ? '0 : r_rdPtr + PW'(1);
    if (w_wrEn) w_wrPtrNxt = (r_wrPtr == LAST) ? '0 : r_wrPtr + PW'(1);
    case ({w_wrEn, w_rdEn})
      2'b10:   w_countNxt = r_count + CW'(1);
      2'b01:   w_countNxt = r_count - CW'(1);
      default: w_countNxt = r_count;
    endcase
  end

  // Storage is cleared on reset so z is never X, even while lz is low.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < fifo_sz; i++) r_mem[i] <= '0;
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wrEn) r_mem[r_wrPtr] <= d;
      r_rdPtr <= w_rdPtrNxt;
      r_wrPtr <= w_wrPtrNxt;
      r_count <= w_countNxt;
    end
  end

`ifndef SYNTHESIS
  a_countBound : assert property (@(posedge clk) disable iff (arst) r_count <= DEPTH);
  a_headStable : assert property (@(posedge clk) disable iff (arst)
                                  (lz && !vz) |=> $stable(z));
`endif

endmodule

// File: tb/tb_mgc_chan_fifo_wait_grn.sv
// Drives a 4-deep and a 3-deep FIFO with the same stimulus and checks both
// against queue-based reference models of the channel rules.
module tb_mgc_chan_fifo_wait_grn;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       ld = 1'b0;
  logic [7:0] d = 8'h00;
  logic       vz = 1'b0;

  logic       vd4, lz4, afull4;
  logic [7:0] z4;
  logic [2:0] size4;
  logic       vd3, lz3, afull3;
  logic [7:0] z3;
  logic [2:0] size3;

  int nCmp = 0;
  int nFail = 0;
  logic [7:0] q4[$];
  logic [7:0] q3[$];

  always #5 clk = ~clk;

  mgc_chan_fifo_wait_grn #(.rscid(1), .width(8), .fifo_sz(4), .ph_log2(2), .afull_lvl(3)) u_dut4 (
    .clk(clk), .arst(arst), .ld(ld), .d(d), .vd(vd4), .lz(lz4), .z(z4), .vz(vz),
    .size(size4), .afull(afull4)
  );

  mgc_chan_fifo_wait_grn #(.rscid(2), .width(8), .fifo_sz(3), .ph_log2(2), .afull_lvl(2)) u_dut3 (
    .clk(clk), .arst(arst), .ld(ld), .d(d), .vd(vd3), .lz(lz3), .z(z3), .vz(vz),
    .size(size3), .afull(afull3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output of both DUTs against the queue models.
  task automatic checkAll(input string phase);
    checkOutput({phase, " vd4"}, 32'(vd4), 32'(q4.size() < 4));
    checkOutput({phase, " lz4"}, 32'(lz4), 32'(q4.size() != 0));
    checkOutput({phase, " size4"}, 32'(size4), 32'(q4.size()));
    checkOutput({phase, " afull4"}, 32'(afull4), 32'(q4.size() >= 3));
    if (q4.size() != 0) checkOutput({phase, " z4"}, 32'(z4), 32'(q4[0]));
    checkOutput({phase, " vd3"}, 32'(vd3), 32'(q3.size() < 3));
    checkOutput({phase, " lz3"}, 32'(lz3), 32'(q3.size() != 0));
    checkOutput({phase, " size3"}, 32'(size3), 32'(q3.size()));
    checkOutput({phase, " afull3"}, 32'(afull3), 32'(q3.size() >= 2));
    if (q3.size() != 0) checkOutput({phase, " z3"}, 32'(z3), 32'(q3[0]));
  endtask

  // Called between edges: check, drive, clock, then advance the models.
  task automatic applyStimulus(input string phase, input logic iLd, input logic [7:0] iD, input logic iVz);
    logic wr4, rd4, wr3, rd3;
    checkAll(phase);
    ld = iLd;
    d  = iD;
    vz = iVz;
    wr4 = iLd && (q4.size() < 4);
    rd4 = iVz && (q4.size() != 0);
    wr3 = iLd && (q3.size() < 3);
    rd3 = iVz && (q3.size() != 0);
    @(posedge clk);
    if (rd4) void'(q4.pop_front());
    if (wr4) q4.push_back(iD);
    if (rd3) void'(q3.pop_front());
    if (wr3) q3.push_back(iD);
    @(negedge clk);
    #1;
  endtask

  // Asynchronous reset pulse in the middle of the low clock phase.
  task automatic pulseReset();
    ld = 1'b0;
    vz = 1'b0;
    #2 arst = 1'b1;
    #1;
    checkOutput("rst vd4", 32'(vd4), 32'd0);
    checkOutput("rst lz4", 32'(lz4), 32'd0);
    checkOutput("rst size4", 32'(size4), 32'd0);
    checkOutput("rst afull4", 32'(afull4), 32'd0);
    checkOutput("rst z4", 32'(z4), 32'd0);
    checkOutput("rst vd3", 32'(vd3), 32'd0);
    checkOutput("rst lz3", 32'(lz3), 32'd0);
    checkOutput("rst size3", 32'(size3), 32'd0);
    q4.delete();
    q3.delete();
    @(negedge clk);
    arst = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] val;
    $display("[TB] start");
    repeat (2) @(negedge clk);
    checkOutput("init vd4", 32'(vd4), 32'd0);
    checkOutput("init z4", 32'(z4), 32'd0);
    arst = 1'b0;
    #1;
    checkOutput("release vd4", 32'(vd4), 32'd1);

    // Reset pulse with a word buffered
    applyStimulus("pre", 1'b1, 8'h99, 1'b0);
    pulseReset();
    checkOutput("post vd4", 32'(vd4), 32'd1);

    // Fill, drop a write when full, then drain in order
    applyStimulus("fill", 1'b1, 8'h11, 1'b0);
    applyStimulus("fill", 1'b1, 8'h22, 1'b0);
    applyStimulus("fill", 1'b1, 8'h33, 1'b0);
    checkOutput("fill afull4", 32'(afull4), 32'd1);
    applyStimulus("fill", 1'b1, 8'h44, 1'b0);
    checkOutput("full vd4", 32'(vd4), 32'd0);
    checkOutput("full size4", 32'(size4), 32'd4);
    applyStimulus("drop", 1'b1, 8'h55, 1'b0);
    checkOutput("drop head4", 32'(z4), 32'h11);
    for (int i = 0; i < 4; i++) applyStimulus("drain", 1'b0, 8'h00, 1'b1);
    checkOutput("drained lz4", 32'(lz4), 32'd0);
    checkOutput("drained size4", 32'(size4), 32'd0);
    pulseReset();

    // Streaming with ld and vz both held high
    for (int i = 0; i < 21; i++) applyStimulus("stream", 1'b1, 8'(i), 1'b1);
    checkOutput("stream size4", 32'(size4), 32'd1);
    checkOutput("stream z4", 32'(z4), 32'd20);
    pulseReset();

    // Full with simultaneous read: write rejected, then accepted
    for (int i = 0; i < 4; i++) applyStimulus("fill2", 1'b1, 8'(8'h60 + i), 1'b0);
    applyStimulus("fullrd", 1'b1, 8'hAA, 1'b1);
    checkOutput("fullrd size4", 32'(size4), 32'd3);
    applyStimulus("fullwr", 1'b1, 8'hAA, 1'b0);
    checkOutput("fullwr size4", 32'(size4), 32'd4);
    checkOutput("fullwr head4", 32'(z4), 32'h61);
    pulseReset();

    // Randomized traffic; the 3-deep instance covers non-power-of-two wrap
    for (int i = 0; i < 300; i++) begin
      val = 8'($urandom);
      applyStimulus("rand", 1'($urandom_range(0, 1)), val, 1'($urandom_range(0, 1)));
    end

    // Reset with two words buffered; no stale data afterwards
    pulseReset();
    applyStimulus("mid", 1'b1, 8'hC1, 1'b0);
    applyStimulus("mid", 1'b1, 8'hC2, 1'b0);
    pulseReset();
    applyStimulus("after", 1'b1, 8'h5A, 1'b0);
    checkOutput("after z4", 32'(z4), 32'h5A);
    checkOutput("after lz4", 32'(lz4), 32'd1);
    checkOutput("after z3", 32'(z3), 32'h5A);
    applyStimulus("after", 1'b0, 8'h00, 1'b1);
    checkOutput("after empty lz4", 32'(lz4), 32'd0);
    checkAll("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
